ex_stage: RTL and testbench

//  Execute stage of the 5-stage RV32I pipeline, directly downstream of the ID/EX register.

---
 rtl/ex_stage.sv | 216 +++++++++++++++++++++
 tb/tb_ex_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage RV32I pipeline.
// Forwards rs1/rs2 from MEM and WB, decodes ALU control, runs the ALU,
// resolves branches, and holds the EX/MEM pipeline register.
// Branch outcome and target are combinational; everything else is
// registered and feeds the MEM stage one cycle later.
//
// Load semantics of the EX/MEM register: reset clears it (a bubble);
// otherwise it loads when write=1 and holds when write=0. There is no
// valid/ready handshake; stalls are expressed solely through write.

module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write,
  input  logic [XLEN-1:0] IMM_EX,
  input  logic [XLEN-1:0] REG_DATA1_EX,
  input  logic [XLEN-1:0] REG_DATA2_EX,
  input  logic [XLEN-1:0] PC_EX,
  input  logic [2:0]      FUNCT3_EX,
  input  logic [6:0]      FUNCT7_EX,
  input  logic [6:0]      OPCODE_EX,
  input  logic [4:0]      RD_EX,
  input  logic [4:0]      RS1_EX,
  input  logic [4:0]      RS2_EX,
  input  logic            RegWrite_EX,
  input  logic            MemtoReg_EX,
  input  logic            MemRead_EX,
  input  logic            MemWrite_EX,
  input  logic            ALUSrc_EX,
  input  logic            Branch_EX,
  input  logic [1:0]      ALUop_EX,
  input  logic [XLEN-1:0] ALU_OUT_MEM,
  input  logic [4:0]      RD_MEM,
  input  logic            RegWrite_MEM,
  input  logic [XLEN-1:0] WB_DATA,
  input  logic [4:0]      RD_WB,
  input  logic            RegWrite_WB,
  output logic            PCSrc_EX,
  output logic [XLEN-1:0] BRANCH_TARGET_EX,
  output logic [XLEN-1:0] ALU_OUT_MEM_o,
  output logic [XLEN-1:0] STORE_DATA_MEM,
  output logic [4:0]      RD_MEM_o,
  output logic            RegWrite_MEM_o,
  output logic            MemtoReg_MEM_o,
  output logic            MemRead_MEM_o,
  output logic            MemWrite_MEM_o,
  output logic            ZERO_MEM
);

  // ALUop encodings coming from the main decoder
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_PASS_B = 2'b11;

  // Internal ALU operation selector
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [6:0] OPC_OP = 7'b0110011;

  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;
  logic            br_cond;

  logic fwd_a_mem;
  logic fwd_a_wb;
  logic fwd_b_mem;
  logic fwd_b_wb;

  // Hazard match terms; x0 never forwards since it is hardwired to zero
  assign fwd_a_mem = RegWrite_MEM && (RD_MEM != 5'd0) && (RD_MEM == RS1_EX);
  assign fwd_a_wb  = RegWrite_WB  && (RD_WB  != 5'd0) && (RD_WB  == RS1_EX);
  assign fwd_b_mem = RegWrite_MEM && (RD_MEM != 5'd0) && (RD_MEM == RS2_EX);
  assign fwd_b_wb  = RegWrite_WB  && (RD_WB  != 5'd0) && (RD_WB  == RS2_EX);

  // Forward rs1: the younger MEM result takes priority over WB
  always_comb begin
    fwd_a = REG_DATA1_EX;
    if (fwd_a_mem) begin
      fwd_a = ALU_OUT_MEM;
    end else if (fwd_a_wb) begin
      fwd_a = WB_DATA;
    end
  end

  // Forward rs2 with the same priority as rs1
  always_comb begin
    fwd_b = REG_DATA2_EX;
    if (fwd_b_mem) begin
      fwd_b = ALU_OUT_MEM;
    end else if (fwd_b_wb) begin
      fwd_b = WB_DATA;
    end
  end

  // Operand B is the immediate for I/S/U forms; store data is always fwd_b
  always_comb begin
    op_a = fwd_a;
    op_b = ALUSrc_EX ? IMM_EX : fwd_b;
  end

  // ALU control decode; sub/sra keyed on funct7[5], sub only for R-type
  always_comb begin
    alu_sel = ALU_ADD;
    case (ALUop_EX)
      ALUOP_ADD:    alu_sel = ALU_ADD;
      ALUOP_BRANCH: alu_sel = ALU_SUB;
      ALUOP_PASS_B: alu_sel = ALU_PASS;
      ALUOP_FUNCT: begin
        case (FUNCT3_EX)
          3'b000:  alu_sel = ((OPCODE_EX == OPC_OP) && FUNCT7_EX[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_sel = ALU_SLL;
          3'b010:  alu_sel = ALU_SLT;
          3'b011:  alu_sel = ALU_SLTU;
          3'b100:  alu_sel = ALU_XOR;
          3'b101:  alu_sel = FUNCT7_EX[5] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_sel = ALU_OR;
          default: alu_sel = ALU_AND;
        endcase
      end
      default: alu_sel = ALU_ADD;
    endcase
  end

  // ALU datapath; shifts use op_b[4:0], arithmetic wraps with no flags
  always_comb begin
    alu_result = '0;
    case (alu_sel)
      ALU_ADD:  alu_result = op_a + op_b;
      ALU_SUB:  alu_result = op_a - op_b;
      ALU_SLL:  alu_result = op_a << op_b[4:0];
      ALU_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? 32'd1 : 32'd0;
      ALU_SLTU: alu_result = (op_a < op_b) ? 32'd1 : 32'd0;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_SRL:  alu_result = op_a >> op_b[4:0];
      ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> op_b[4:0]);
      ALU_OR:   alu_result = op_a | op_b;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_PASS: alu_result = op_b;
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

  // Branch comparisons use forwarded registers, never the immediate
  always_comb begin
    br_eq  = (fwd_a == fwd_b);
    br_lt  = ($signed(fwd_a) < $signed(fwd_b));
    br_ltu = (fwd_a < fwd_b);
  end

  // Branch condition select by funct3; 010/011 are not branches
  always_comb begin
    br_cond = 1'b0;
    case (FUNCT3_EX)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = !br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = !br_lt;
      3'b110:  br_cond = br_ltu;
      3'b111:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  // Redirect to IF and hazard unit; live even while reset is asserted
  always_comb begin
    PCSrc_EX         = Branch_EX && br_cond;
    BRANCH_TARGET_EX = PC_EX + IMM_EX;
  end

  // EX/MEM pipeline register: reset wins, then load on write, else hold
  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_OUT_MEM_o  <= '0;
      STORE_DATA_MEM <= '0;
      RD_MEM_o       <= '0;
      RegWrite_MEM_o <= 1'b0;
      MemtoReg_MEM_o <= 1'b0;
      MemRead_MEM_o  <= 1'b0;
      MemWrite_MEM_o <= 1'b0;
      ZERO_MEM       <= 1'b0;
    end else if (write) begin
      ALU_OUT_MEM_o  <= alu_result;
      STORE_DATA_MEM <= fwd_b;
      RD_MEM_o       <= RD_EX;
      RegWrite_MEM_o <= RegWrite_EX;
      MemtoReg_MEM_o <= MemtoReg_EX;
      MemRead_MEM_o  <= MemRead_EX;
      MemWrite_MEM_o <= MemWrite_EX;
      ZERO_MEM       <= alu_zero;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of ex_stage forwarding, ALU decode,
// branch resolution and EX/MEM register reset/hold behaviour.

module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [31:0] IMM_EX, REG_DATA1_EX, REG_DATA2_EX, PC_EX;
  logic [2:0]  FUNCT3_EX;
  logic [6:0]  FUNCT7_EX, OPCODE_EX;
  logic [4:0]  RD_EX, RS1_EX, RS2_EX;
  logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, ALUSrc_EX, Branch_EX;
  logic [1:0]  ALUop_EX;
  logic [31:0] ALU_OUT_MEM, WB_DATA;
  logic [4:0]  RD_MEM, RD_WB;
  logic        RegWrite_MEM, RegWrite_WB;
  logic        PCSrc_EX;
  logic [31:0] BRANCH_TARGET_EX, ALU_OUT_MEM_o, STORE_DATA_MEM;
  logic [4:0]  RD_MEM_o;
  logic        RegWrite_MEM_o, MemtoReg_MEM_o, MemRead_MEM_o, MemWrite_MEM_o, ZERO_MEM;

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .write(write),
    .IMM_EX(IMM_EX), .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX),
    .PC_EX(PC_EX), .FUNCT3_EX(FUNCT3_EX), .FUNCT7_EX(FUNCT7_EX), .OPCODE_EX(OPCODE_EX),
    .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX),
    .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX),
    .MemWrite_EX(MemWrite_EX), .ALUSrc_EX(ALUSrc_EX), .Branch_EX(Branch_EX),
    .ALUop_EX(ALUop_EX), .ALU_OUT_MEM(ALU_OUT_MEM), .RD_MEM(RD_MEM),
    .RegWrite_MEM(RegWrite_MEM), .WB_DATA(WB_DATA), .RD_WB(RD_WB),
    .RegWrite_WB(RegWrite_WB), .PCSrc_EX(PCSrc_EX), .BRANCH_TARGET_EX(BRANCH_TARGET_EX),
    .ALU_OUT_MEM_o(ALU_OUT_MEM_o), .STORE_DATA_MEM(STORE_DATA_MEM), .RD_MEM_o(RD_MEM_o),
    .RegWrite_MEM_o(RegWrite_MEM_o), .MemtoReg_MEM_o(MemtoReg_MEM_o),
    .MemRead_MEM_o(MemRead_MEM_o), .MemWrite_MEM_o(MemWrite_MEM_o), .ZERO_MEM(ZERO_MEM)
  );

  // Compare one observed value against its hand-computed expectation
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Quiet ID/EX and forwarding inputs: nop-like, no hazards
  task automatic idle();
    IMM_EX = 0; REG_DATA1_EX = 0; REG_DATA2_EX = 0; PC_EX = 0;
    FUNCT3_EX = 0; FUNCT7_EX = 0; OPCODE_EX = 7'b0110011;
    RD_EX = 0; RS1_EX = 0; RS2_EX = 0;
    RegWrite_EX = 0; MemtoReg_EX = 0; MemRead_EX = 0; MemWrite_EX = 0;
    ALUSrc_EX = 0; Branch_EX = 0; ALUop_EX = 2'b10;
    ALU_OUT_MEM = 0; RD_MEM = 0; RegWrite_MEM = 0;
    WB_DATA = 0; RD_WB = 0; RegWrite_WB = 0;
  endtask

  // R-type ALU op on unforwarded register values
  task automatic rtype(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    idle();
    FUNCT3_EX = f3; FUNCT7_EX = f7; REG_DATA1_EX = a; REG_DATA2_EX = b;
    RS1_EX = 5'd10; RS2_EX = 5'd11; RD_EX = 5'd12; RegWrite_EX = 1;
  endtask

  // Branch with operands taken straight from the register file
  task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    idle();
    OPCODE_EX = 7'b1100011; ALUop_EX = 2'b01; Branch_EX = 1; FUNCT3_EX = f3;
    REG_DATA1_EX = a; REG_DATA2_EX = b; RS1_EX = 5'd1; RS2_EX = 5'd2;
    PC_EX = 32'h100; IMM_EX = 32'hFFFF_FFF8;
  endtask

  initial begin
    idle();
    write = 1;
    reset = 1;
    tick();
    check("reset_alu", ALU_OUT_MEM_o, 32'h0);
    check("reset_store", STORE_DATA_MEM, 32'h0);
    check("reset_rd", {27'd0, RD_MEM_o}, 32'd0);
    check("reset_ctrl", {28'd0, RegWrite_MEM_o, MemtoReg_MEM_o, MemRead_MEM_o, MemWrite_MEM_o}, 32'd0);
    check("reset_zero", {31'd0, ZERO_MEM}, 32'd0);
    reset = 0;

    // add x3,x1,x2 with 5 + 7
    idle();
    RS1_EX = 1; RS2_EX = 2; RD_EX = 3; REG_DATA1_EX = 5; REG_DATA2_EX = 7; RegWrite_EX = 1;
    #1 check("add_pcsrc", {31'd0, PCSrc_EX}, 32'd0);
    tick();
    check("add_alu", ALU_OUT_MEM_o, 32'd12);
    check("add_rd", {27'd0, RD_MEM_o}, 32'd3);
    check("add_regwrite", {31'd0, RegWrite_MEM_o}, 32'd1);
    check("add_store", STORE_DATA_MEM, 32'd7);
    check("add_zero", {31'd0, ZERO_MEM}, 32'd0);

    // sub with rs1 hit in both MEM (100) and WB (9): MEM wins, 100 - 1
    idle();
    FUNCT7_EX = 7'b0100000; RS1_EX = 4; RS2_EX = 5; RD_EX = 6; RegWrite_EX = 1;
    REG_DATA1_EX = 55; REG_DATA2_EX = 1;
    RD_MEM = 4; RegWrite_MEM = 1; ALU_OUT_MEM = 100;
    RD_WB = 4; RegWrite_WB = 1; WB_DATA = 9;
    tick();
    check("sub_fwd_mem", ALU_OUT_MEM_o, 32'd99);

    // x0 never forwards; rs2 forwarded from WB into store data, op B is imm
    idle();
    RS1_EX = 0; RD_MEM = 0; RegWrite_MEM = 1; ALU_OUT_MEM = 77; REG_DATA1_EX = 32'h11;
    ALUop_EX = 2'b00; ALUSrc_EX = 1; IMM_EX = 32'h22; MemWrite_EX = 1;
    RS2_EX = 6; RD_WB = 6; RegWrite_WB = 1; WB_DATA = 32'hABC; REG_DATA2_EX = 1;
    tick();
    check("x0_nofwd_alu", ALU_OUT_MEM_o, 32'h33);
    check("store_fwd_wb", STORE_DATA_MEM, 32'hABC);
    check("store_memwrite", {31'd0, MemWrite_MEM_o}, 32'd1);
    check("store_regwrite", {31'd0, RegWrite_MEM_o}, 32'd0);

    // bne equal operands: not taken, target 0x100-8
    branch(3'b001, 32'd3, 32'd3);
    #1;
    check("bne_eq_pcsrc", {31'd0, PCSrc_EX}, 32'd0);
    check("bne_target", BRANCH_TARGET_EX, 32'h0000_00F8);
    tick();
    check("bne_eq_zero", {31'd0, ZERO_MEM}, 32'd1);
    REG_DATA2_EX = 4;
    #1;
    check("bne_ne_pcsrc", {31'd0, PCSrc_EX}, 32'd1);
    check("bne_ne_target", BRANCH_TARGET_EX, 32'h0000_00F8);
    tick();
    check("bne_ne_zero", {31'd0, ZERO_MEM}, 32'd0);
    check("bne_ne_diff", ALU_OUT_MEM_o, 32'hFFFF_FFFF);

    // Other branch conditions, including signed vs unsigned
    branch(3'b100, 32'hFFFF_FFFF, 32'd1);
    #1 check("blt_taken", {31'd0, PCSrc_EX}, 32'd1);
    branch(3'b110, 32'hFFFF_FFFF, 32'd1);
    #1 check("bltu_not", {31'd0, PCSrc_EX}, 32'd0);
    branch(3'b111, 32'hFFFF_FFFF, 32'd1);
    #1 check("bgeu_taken", {31'd0, PCSrc_EX}, 32'd1);
    branch(3'b101, 32'd1, 32'd1);
    #1 check("bge_eq_taken", {31'd0, PCSrc_EX}, 32'd1);
    branch(3'b010, 32'd1, 32'd1);
    #1 check("f3_010_not", {31'd0, PCSrc_EX}, 32'd0);
    branch(3'b000, 32'd1, 32'd1);
    Branch_EX = 0;
    #1 check("beq_nobranch", {31'd0, PCSrc_EX}, 32'd0);
    // branch compare uses forwarded value (MEM 3 vs rs2 3 -> beq taken)
    branch(3'b000, 32'd9, 32'd3);
    RD_MEM = 1; RegWrite_MEM = 1; ALU_OUT_MEM = 3;
    #1 check("beq_fwd_taken", {31'd0, PCSrc_EX}, 32'd1);

    // Shifts and compares
    rtype(3'b101, 7'b0100000, 32'h8000_0000, 32'd4);
    tick(); check("sra", ALU_OUT_MEM_o, 32'hF800_0000);
    rtype(3'b101, 7'b0000000, 32'h8000_0000, 32'd4);
    tick(); check("srl", ALU_OUT_MEM_o, 32'h0800_0000);
    rtype(3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF);
    tick(); check("sltu", ALU_OUT_MEM_o, 32'd1);
    rtype(3'b010, 7'b0000000, 32'd1, 32'hFFFF_FFFF);
    tick(); check("slt", ALU_OUT_MEM_o, 32'd0);
    rtype(3'b001, 7'b0000000, 32'd1, 32'h21);
    tick(); check("sll_shamt5", ALU_OUT_MEM_o, 32'd2);
    rtype(3'b100, 7'b0000000, 32'hF0F0, 32'hFF00);
    tick(); check("xor", ALU_OUT_MEM_o, 32'h0FF0);
    rtype(3'b110, 7'b0000000, 32'hF0F0, 32'hFF00);
    tick(); check("or", ALU_OUT_MEM_o, 32'hFFF0);
    rtype(3'b111, 7'b0000000, 32'hF0F0, 32'hFF00);
    tick(); check("and", ALU_OUT_MEM_o, 32'hF000);

    // addi with imm[10] set: funct7[5]=1 must not select sub on I-type
    rtype(3'b000, 7'b0100000, 32'd10, 32'd0);
    OPCODE_EX = 7'b0010011; ALUSrc_EX = 1; IMM_EX = 32'h400;
    tick(); check("addi_not_sub", ALU_OUT_MEM_o, 32'h40A);

    // ALUop 11 passes operand B (lui-style)
    idle();
    ALUop_EX = 2'b11; ALUSrc_EX = 1; IMM_EX = 32'h1234_5000; REG_DATA1_EX = 32'h77; RD_EX = 9;
    RegWrite_EX = 1;
    tick();
    check("pass_b", ALU_OUT_MEM_o, 32'h1234_5000);
    check("pass_b_rd", {27'd0, RD_MEM_o}, 32'd9);

    // Hold for two cycles with write=0 while inputs change
    rtype(3'b000, 7'b0000000, 32'd40, 32'd2);
    MemtoReg_EX = 1; MemRead_EX = 1; RD_EX = 20;
    write = 0;
    tick();
    check("hold1_alu", ALU_OUT_MEM_o, 32'h1234_5000);
    tick();
    check("hold2_alu", ALU_OUT_MEM_o, 32'h1234_5000);
    check("hold2_rd", {27'd0, RD_MEM_o}, 32'd9);
    check("hold2_memread", {31'd0, MemRead_MEM_o}, 32'd0);

    // Reset with write=1: reset wins; PCSrc still tracks live inputs
    write = 1;
    reset = 1;
    branch(3'b000, 32'd5, 32'd5);
    #1 check("reset_pcsrc_live", {31'd0, PCSrc_EX}, 32'd1);
    tick();
    check("reset2_alu", ALU_OUT_MEM_o, 32'h0);
    check("reset2_store", STORE_DATA_MEM, 32'h0);
    check("reset2_rd", {27'd0, RD_MEM_o}, 32'd0);
    check("reset2_ctrl", {27'd0, RegWrite_MEM_o, MemtoReg_MEM_o, MemRead_MEM_o, MemWrite_MEM_o, ZERO_MEM}, 32'd0);
    reset = 0;

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
